vc_flit_sink: RTL

Downstream receiving end of a router output port. Accepts flits from the port's `data_o`/`valid_flit_o` pair into per-VC FIFOs, drives the per-VC `on_off` and `vc_allocatable` back-pressure that the router expects on that port, and drains buffered flits through a single valid/ready output. It serves as the bench-side sink model of a neighbour input port and as the synthesizable termination of unused mesh edges.

---
 rtl/vc_flit_sink.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/vc_flit_sink.sv
// vc_flit_sink: receiving end of a router output port.
// Per-VC FIFOs with packet-framing tracking, registered on/off hysteresis
// and allocatable flags, and a round-robin drain into a one-entry output
// register. Flit layout: [1:0] label, [2 +: VC_W] vc_id, remaining bits payload.

module vc_flit_sink_lane #(
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_MARGIN  = 2,
    parameter int ON_MARGIN   = 4,
    parameter int FLIT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_i,
    input  logic [1:0]        label_i,
    input  logic [FLIT_W-1:0] flit_i,
    input  logic              pop_i,
    output logic [FLIT_W-1:0] head_o,
    output logic              empty_o,
    output logic              on_off_o,
    output logic              alloc_o,
    output logic              ovf_o,
    output logic              perr_o
);
    localparam int AW = $clog2(BUFFER_SIZE);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH   = CW'(BUFFER_SIZE);
    localparam logic [CW-1:0] OFF_LVL = CW'(OFF_MARGIN);
    localparam logic [CW-1:0] ON_LVL  = CW'(ON_MARGIN);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [1:0] L_HEAD = 2'd0, L_BODY = 2'd1, L_TAIL = 2'd2, L_HEADTAIL = 2'd3;

    logic [BUFFER_SIZE-1:0][FLIT_W-1:0] mem_q;
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d, free;
    logic          open_q, open_d, on_off_q, alloc_q;
    logic          full, push;

    // Fullness is judged on the pre-edge count, so a same-cycle pop never rescues a write.
    assign full    = (cnt_q == DEPTH);
    assign push    = wr_i && !full;
    assign ovf_o   = wr_i && full;
    assign empty_o = (cnt_q == '0);
    assign head_o  = mem_q[rd_ptr_q];
    assign free    = DEPTH - cnt_q;
    assign on_off_o = on_off_q;
    assign alloc_o  = alloc_q;

    // Packet framing: every arriving flit steers OPEN/CLOSED, even if dropped.
    always_comb begin
        open_d = open_q;
        perr_o = 1'b0;
        if (wr_i) begin
            case (label_i)
                L_HEAD:     begin perr_o = open_q;  open_d = 1'b1; end
                L_HEADTAIL: begin perr_o = open_q;  open_d = 1'b0; end
                L_BODY:     begin perr_o = !open_q; end
                L_TAIL:     begin perr_o = !open_q; open_d = 1'b0; end
                default:    begin perr_o = 1'b0; end
            endcase
        end
    end

    // Occupancy next-state: push and pop together cancel.
    always_comb begin
        cnt_d = cnt_q;
        case ({push, pop_i})
            2'b10:   cnt_d = cnt_q + CNT_ONE;
            2'b01:   cnt_d = cnt_q - CNT_ONE;
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointers, count, framing state and the registered back-pressure flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            open_q   <= 1'b0;
            on_off_q <= 1'b1;
            alloc_q  <= 1'b1;
        end else begin
            if (push)  wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop_i) rd_ptr_q <= rd_ptr_q + PTR_ONE;
            cnt_q  <= cnt_d;
            open_q <= open_d;
            if (free <= OFF_LVL)     on_off_q <= 1'b0;
            else if (free >= ON_LVL) on_off_q <= 1'b1;
            alloc_q <= !open_q && empty_o;
        end
    end

    // Flit storage; contents are don't-care while the count says empty.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= flit_i;
    end
endmodule

module vc_flit_sink #(
    parameter int VC_NUM      = 2,
    parameter int BUFFER_SIZE = 8,
    parameter int OFF_MARGIN  = 2,
    parameter int ON_MARGIN   = 4,
    parameter int FLIT_W      = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] data_i,
    input  logic              valid_flit_i,
    output logic [VC_NUM-1:0] on_off_o,
    output logic [VC_NUM-1:0] vc_allocatable_o,
    output logic [FLIT_W-1:0] data_o,
    output logic              valid_o,
    input  logic              ready_i,
    output logic              overflow_o,
    output logic              proto_err_o
);
    localparam int VC_W = (VC_NUM > 1) ? $clog2(VC_NUM) : 1;

    logic [VC_NUM-1:0][FLIT_W-1:0] head;
    logic [VC_NUM-1:0] empty, wr_vec, pop_vec, ovf_vec, perr_vec;
    logic [VC_W-1:0]   in_vc, grant, rr_q, rr_d;
    logic              grant_vld, load;
    logic              out_vld_q, ovf_q, perr_q;
    logic [FLIT_W-1:0] out_data_q;

    assign in_vc = data_i[2 +: VC_W];
    assign load  = !out_vld_q || ready_i;

    for (genvar v = 0; v < VC_NUM; v++) begin : g_lane
        assign wr_vec[v] = valid_flit_i && (in_vc == VC_W'(v));
        vc_flit_sink_lane #(
            .BUFFER_SIZE(BUFFER_SIZE), .OFF_MARGIN(OFF_MARGIN),
            .ON_MARGIN(ON_MARGIN), .FLIT_W(FLIT_W)
        ) u_lane (
            .clk(clk), .rst(rst), .wr_i(wr_vec[v]), .label_i(data_i[1:0]),
            .flit_i(data_i), .pop_i(pop_vec[v]), .head_o(head[v]),
            .empty_o(empty[v]), .on_off_o(on_off_o[v]),
            .alloc_o(vc_allocatable_o[v]), .ovf_o(ovf_vec[v]), .perr_o(perr_vec[v])
        );
    end

    // Round-robin search starting at rr_q; pop the winner only when the output register loads.
    always_comb begin
        int idx;
        idx       = 0;
        grant_vld = 1'b0;
        grant     = '0;
        pop_vec   = '0;
        for (int i = 0; i < VC_NUM; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= VC_NUM) idx = idx - VC_NUM;
            if (!grant_vld && !empty[idx]) begin
                grant_vld = 1'b1;
                grant     = VC_W'(idx);
            end
        end
        if (load && grant_vld) pop_vec[grant] = 1'b1;
        rr_d = (grant == VC_W'(VC_NUM - 1)) ? '0 : grant + VC_W'(1);
    end

    // Output register, RR pointer and the one-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld_q  <= 1'b0;
            out_data_q <= '0;
            rr_q       <= '0;
            ovf_q      <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            ovf_q  <= |ovf_vec;
            perr_q <= |perr_vec;
            if (load) begin
                out_vld_q <= grant_vld;
                if (grant_vld) begin
                    out_data_q <= head[grant];
                    rr_q       <= rr_d;
                end
            end
        end
    end

    assign valid_o     = out_vld_q;
    assign data_o      = out_data_q;
    assign overflow_o  = ovf_q;
    assign proto_err_o = perr_q;
endmodule
